// File: rtl/pll_reconfig_sequencer_if.sv
// pll_reconfig_sequencer_if: command side and reconfig-core side signals of the PLL reprogramming sequencer.
interface pll_reconfig_sequencer_if;
    logic       req;
    logic [7:0] mult;
    logic [7:0] div;
    logic       ready;
    logic       done;
    logic       error;
    logic       lock_lost;
    logic       rc_busy;
    logic [3:0] rc_counter_type;
    logic [2:0] rc_counter_param;
    logic [8:0] rc_data_in;
    logic       rc_write_param;
    logic       rc_reconfig;
    logic       rc_reset;
    logic       pll_areset_req;
    logic       pll_locked;
    modport master (
        output req, mult, div, rc_busy, pll_locked,
        input  ready, done, error, lock_lost, rc_counter_type, rc_counter_param,
               rc_data_in, rc_write_param, rc_reconfig, rc_reset, pll_areset_req
    );
    modport slave (
        input  req, mult, div, rc_busy, pll_locked,
        output ready, done, error, lock_lost, rc_counter_type, rc_counter_param,
               rc_data_in, rc_write_param, rc_reconfig, rc_reset, pll_areset_req
    );
endinterface

// File: rtl/pll_reconfig_sequencer.sv
// pll_reconfig_sequencer: writes N/M counter fields to the PLL reconfig core, reconfigures, resets and waits for lock.
module pll_reconfig_sequencer #(
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SETTLE_CYCLES = 16,
    parameter int MAX_RETRY     = 2
) (
    input logic clock,
    input logic reset_n,
    pll_reconfig_sequencer_if.slave bus
);
    localparam int CW = $clog2((LOCK_TIMEOUT > SETTLE_CYCLES ? LOCK_TIMEOUT : SETTLE_CYCLES) + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    typedef enum logic [3:0] {INIT, IDLE, CHECK, LOAD, WR, WWAIT, RCFG, RWAIT, ARST, LOCK, DONE, ERR} state_t;
    state_t state, next;
    logic [7:0] m_q, n_q, v;
    logic [2:0] idx;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry;
    logic [2:0] lock_sync;
    logic armed, error_q, lock_lost_q;
    logic accept, locked, lock_fall, first, in_wr;
    logic [8:0] field;
    assign accept    = state == IDLE && bus.req;
    assign locked    = lock_sync[1];
    assign lock_fall = lock_sync[2] & ~lock_sync[1];
    // cnt restarts on every state change, so cnt==0 marks the first cycle of a state
    assign first     = cnt == '0;
    assign in_wr     = state inside {LOAD, WR, WWAIT};
    assign v         = idx[2] ? m_q : n_q;
    assign field     = idx[1:0] == 2'd0 ? ({1'b0, v} + 9'd1) >> 1 :
                       idx[1:0] == 2'd1 ? {2'b0, v[7:1]} :
                       idx[1:0] == 2'd2 ? {8'b0, v == 8'd1} : {8'b0, v[0]};
    always_comb begin
        next = state;
        unique case (state)
            INIT:  next = IDLE;
            IDLE:  next = accept ? CHECK : IDLE;
            CHECK: next = (m_q == 8'd0 || n_q == 8'd0) ? ERR : LOAD;
            LOAD:  next = WR;
            WR:    next = bus.rc_busy ? WR : WWAIT;
            WWAIT: next = (first || bus.rc_busy) ? WWAIT : idx == 3'd7 ? RCFG : LOAD;
            RCFG:  next = RWAIT;
            RWAIT: next = (first || bus.rc_busy) ? RWAIT : ARST;
            ARST:  next = cnt == CW'(SETTLE_CYCLES - 1) ? LOCK : ARST;
            LOCK:  next = locked ? DONE :
                          cnt != CW'(LOCK_TIMEOUT - 1) ? LOCK :
                          retry < RW'(MAX_RETRY) ? RCFG : ERR;
            DONE:  next = IDLE;
            ERR:   next = IDLE;
            default: next = INIT;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= INIT;
            m_q         <= '0;
            n_q         <= '0;
            idx         <= '0;
            cnt         <= '0;
            retry       <= '0;
            lock_sync   <= '0;
            armed       <= 1'b0;
            error_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state     <= next;
            lock_sync <= {lock_sync[1:0], bus.pll_locked};
            cnt       <= next != state ? '0 : cnt + 1'b1;
            if (accept) begin
                m_q         <= bus.mult;
                n_q         <= bus.div;
                error_q     <= 1'b0;
                lock_lost_q <= 1'b0;
                armed       <= 1'b0;
                retry       <= '0;
            end else if (state == IDLE && armed && lock_fall) begin
                lock_lost_q <= 1'b1;
            end
            if (next == ERR) begin
                error_q <= 1'b1;
                armed   <= 1'b0;
            end
            if (state == DONE)
                armed <= 1'b1;
            if (state == CHECK)
                idx <= '0;
            else if (state == WWAIT && next == LOAD)
                idx <= idx + 1'b1;
            if (state == LOCK && next == RCFG)
                retry <= retry + 1'b1;
        end
    end
    assign bus.ready            = state == IDLE;
    assign bus.done             = state == DONE;
    assign bus.error            = error_q;
    assign bus.lock_lost        = lock_lost_q;
    assign bus.rc_reset         = state == INIT;
    assign bus.rc_write_param   = state == WR && !bus.rc_busy;
    assign bus.rc_reconfig      = state == RCFG;
    assign bus.pll_areset_req   = state == ARST;
    assign bus.rc_counter_type  = in_wr ? {3'b0, idx[2]} : '0;
    assign bus.rc_counter_param = in_wr ? {idx[1], 1'b0, idx[0]} : '0;
    assign bus.rc_data_in       = in_wr ? field : '0;
endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// tb_pll_reconfig_sequencer: random and directed requests against models of the reconfig core and PLL.
module tb_pll_reconfig_sequencer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;
    pll_reconfig_sequencer_if bus ();
    pll_reconfig_sequencer #(.LOCK_TIMEOUT(50), .SETTLE_CYCLES(16), .MAX_RETRY(2)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );
    int errors = 0, checks = 0;
    int busy_len = 3, bc = 0, lock_delay = 10, dc = 0;
    logic noise_en = 1'b0, noise = 1'b0, lock_en = 1'b1, lk = 1'b0, force_low = 1'b0;
    logic [15:0] expq[$];
    int wlog[$];
    int n_wr = 0, n_rcfg = 0, n_done = 0, alen = 0;
    bit armed_m = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic int fval(input int p, input int v);
        return p == 0 ? (v + 1) / 2 : p == 1 ? v / 2 : p == 2 ? int'(v == 1) : v % 2;
    endfunction
    function automatic logic [15:0] fld(input int t, input int p, input int v);
        logic [2:0] code;
        code = 3'(p == 0 ? 0 : p == 1 ? 1 : p == 2 ? 4 : 5);
        return {4'(t), code, 9'(fval(p, v))};
    endfunction
    task automatic push_exp(input int m, input int d);
        for (int t = 0; t < 2; t++)
            for (int p = 0; p < 4; p++)
                expq.push_back(fld(t, p, t == 1 ? m : d));
    endtask
    // reconfig core: busy for busy_len cycles after any strobe, plus optional random busy noise
    always @(posedge clock) begin
        if (bus.rc_write_param || bus.rc_reconfig) bc <= busy_len;
        else if (bc != 0) bc <= bc - 1;
        noise <= noise_en && $urandom_range(0, 3) == 0;
    end
    assign bus.rc_busy = bc != 0 || noise;
    // PLL: loses lock during areset, regains it lock_delay cycles after release when enabled
    always @(posedge clock) begin
        if (bus.pll_areset_req) begin
            lk <= 1'b0;
            dc <= 0;
        end else if (lock_en && !lk) begin
            if (dc >= lock_delay) lk <= 1'b1;
            else dc <= dc + 1;
        end
    end
    assign bus.pll_locked = lk && !force_low;
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.rc_write_param) begin
                n_wr++;
                wlog.push_back(int'(bus.rc_data_in));
                chk("write_while_busy", bus.rc_busy, 0);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_unexpected: got field %h expected no write",
                             {bus.rc_counter_type, bus.rc_counter_param, bus.rc_data_in});
                end else chk("write_field", {bus.rc_counter_type, bus.rc_counter_param, bus.rc_data_in}, expq.pop_front());
            end
            if (bus.rc_reconfig) begin
                n_rcfg++;
                chk("reconfig_after_all_writes", expq.size(), 0);
            end
            if (bus.done) n_done++;
            if (bus.pll_areset_req) alen++;
            else if (alen != 0) begin
                chk("areset_settle_len", alen, 16);
                alen = 0;
            end
        end else alen = 0;
    end
    task automatic run_op(input int m, input int d, input bit lk_ok, input int dly);
        int w0, r0, d0, t, err_t;
        bit valid, ok;
        valid = m != 0 && d != 0;
        ok = valid && lk_ok;
        lock_en = lk_ok;
        lock_delay = dly;
        t = 0;
        while (!bus.ready && t < 3000) begin @(negedge clock); t++; end
        chk("ready_before_req", bus.ready, 1);
        w0 = n_wr; r0 = n_rcfg; d0 = n_done;
        if (valid) push_exp(m, d);
        bus.req = 1'b1; bus.mult = 8'(m); bus.div = 8'(d);
        @(negedge clock);
        bus.req = 1'b0; bus.mult = 8'($urandom); bus.div = 8'($urandom);
        chk("accept_ready_low", bus.ready, 0);
        chk("accept_clears_error", bus.error, 0);
        chk("accept_clears_lock_lost", bus.lock_lost, 0);
        t = 0; err_t = -1;
        while (!bus.ready && t < 3000) begin
            if (bus.error && err_t < 0) err_t = t;
            bus.req = $urandom_range(0, 3) == 0;
            @(negedge clock);
            t++;
        end
        bus.req = 1'b0;
        chk("op_completes", t < 3000, 1);
        if (!valid) chk("invalid_error_latency", err_t >= 0 && err_t <= 3, 1);
        chk("done_pulses", n_done - d0, ok);
        chk("error_flag", bus.error, !ok);
        chk("write_count", n_wr - w0, valid ? 8 : 0);
        chk("reconfig_count", n_rcfg - r0, !valid ? 0 : lk_ok ? 1 : 3);
        chk("fields_consumed", expq.size(), 0);
        armed_m = ok;
    endtask
    initial begin
        int lit1[8] = '{3, 2, 0, 1, 6, 6, 0, 0};
        int lit2[8] = '{1, 0, 1, 1, 1, 0, 1, 1};
        int t, m, d;
        bus.req = 1'b0; bus.mult = '0; bus.div = '0;
        chk("model_high_5", fval(0, 5), 3);
        chk("model_low_12", fval(1, 12), 6);
        chk("model_bypass_1", fval(2, 1), 1);
        chk("model_odd_12", fval(3, 12), 0);
        repeat (2) @(negedge clock);
        chk("rst_rc_reset", bus.rc_reset, 1);
        chk("rst_outputs_zero", {bus.ready, bus.done, bus.error, bus.lock_lost, bus.rc_write_param,
                                 bus.rc_reconfig, bus.pll_areset_req, bus.rc_counter_type,
                                 bus.rc_counter_param, bus.rc_data_in}, 0);
        reset_n = 1'b1;
        #1 chk("init_rc_reset", bus.rc_reset, 1);
        chk("init_not_ready", bus.ready, 0);
        @(negedge clock);
        chk("idle_ready", bus.ready, 1);
        chk("idle_rc_reset_low", bus.rc_reset, 0);
        wlog.delete();
        run_op(12, 5, 1, 30);
        for (int i = 0; i < 8; i++) chk("t1_write_data", wlog[i], lit1[i]);
        wlog.delete();
        busy_len = 1;
        run_op(1, 1, 1, 5);
        for (int i = 0; i < 8; i++) chk("t2_write_data", wlog[i], lit2[i]);
        run_op(0, 7, 1, 5);
        run_op(9, 4, 0, 0);
        chk("timeout_ready", bus.ready, 1);
        busy_len = 2;
        run_op(12, 5, 1, 10);
        @(negedge clock);
        force_low = 1'b1;
        repeat (3) @(negedge clock);
        chk("lock_lost_set", bus.lock_lost, armed_m);
        force_low = 1'b0;
        repeat (4) @(negedge clock);
        chk("lock_lost_sticky", bus.lock_lost, 1);
        run_op(7, 3, 1, 8);
        run_op(0, 4, 1, 8);
        force_low = 1'b1;
        repeat (5) @(negedge clock);
        chk("lock_lost_disarmed", bus.lock_lost, 0);
        force_low = 1'b0;
        for (int i = 0; i < 16; i++) begin
            busy_len = $urandom_range(0, 4);
            noise_en = $urandom_range(0, 1) == 1;
            m = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(0, 4) == 0 ? 255 : $urandom_range(1, 255);
            d = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(0, 4) == 0 ? 1 : $urandom_range(1, 255);
            run_op(m, d, $urandom_range(0, 5) != 0, $urandom_range(0, 35));
        end
        noise_en = 1'b0;
        busy_len = 4;
        lock_en = 1'b1;
        push_exp(12, 5);
        bus.req = 1'b1; bus.mult = 8'd12; bus.div = 8'd5;
        @(negedge clock);
        bus.req = 1'b0;
        t = 0;
        while (!bus.rc_write_param && t < 500) begin @(negedge clock); t++; end
        chk("reset_test_write_seen", t < 500, 1);
        @(negedge clock);
        reset_n = 1'b0;
        #1 chk("midop_strobes_low", {bus.rc_write_param, bus.rc_reconfig, bus.pll_areset_req, bus.done}, 0);
        chk("midop_rc_reset", bus.rc_reset, 1);
        chk("midop_ready_low", bus.ready, 0);
        chk("midop_fields_zero", {bus.rc_counter_type, bus.rc_counter_param, bus.rc_data_in}, 0);
        expq.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1 chk("release_rc_reset", bus.rc_reset, 1);
        @(negedge clock);
        chk("release_ready", bus.ready, 1);
        run_op(12, 5, 1, 12);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
